// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the result sources, the round-robin arbiter and
// the writeback path. The arbiter uses the slave view; whoever drives the
// requests and consumes the output register uses the master view.
interface mux_rr_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 10
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS-1:0]       ack;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          grant_sel;

  modport master (
    output in_bus, req, out_ready,
    input  ack, out_data, out_valid, grant_sel
  );

  modport slave (
    input  in_bus, req, out_ready,
    output ack, out_data, out_valid, grant_sel
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter plus output register for the shared result mux.
// One requester is granted per transfer; its word is captured into out_data
// and offered downstream on a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | out_data holds nothing; any request loads on the next edge
// FULL  | out_data holds an untaken word; reload only when out_ready
module mux_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 10
) (
  input  logic            clk,
  input  logic            reset,
  mux_rr_arbiter_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    grant_q;
  logic [SEL_W-1:0]    ptr;

  logic                load;
  logic [SEL_W-1:0]    g;
  logic                found;
  logic [WIDTH-1:0]    sel_word;
  logic [CHANNELS-1:0] ack_c;

  // A load is blocked during reset so that no ack is issued for a word that
  // the reset is about to discard.
  assign load = (|bus.req) && ((state == EMPTY) || bus.out_ready) && !reset;

  // Pick the first requester at or after ptr, wrapping past the last channel.
  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % CHANNELS]) begin
        found = 1'b1;
        g     = SEL_W'((int'(ptr) + k) % CHANNELS);
      end
    end
  end

  // Mux out the granted word and raise its one-hot ack in the load cycle.
  always_comb begin
    sel_word = bus.in_bus[g*WIDTH +: WIDTH];
    ack_c    = '0;
    if (load) begin
      ack_c[g] = 1'b1;
    end
  end

  // Output register FSM; the pointer only advances when a word is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      data_q  <= '0;
      grant_q <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (!load && bus.out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (load) begin
        data_q  <= sel_word;
        grant_q <= g;
        ptr     <= (g == SEL_W'(CHANNELS - 1)) ? '0 : g + SEL_W'(1);
      end
    end
  end

  assign bus.ack       = ack_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state == FULL);
  assign bus.grant_sel = grant_q;

  // At most one channel is acknowledged per cycle.
  ack_onehot_a : assert property (@(posedge clk) $onehot0(bus.ack));

  // A stalled word must not change under the consumer.
  hold_stable_a : assert property (@(posedge clk)
    (!reset && bus.out_valid && !bus.out_ready) |=> (reset || $stable(bus.out_data)));
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;
  localparam int WIDTH    = 32;
  localparam int CHANNELS = 10;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  mux_rr_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  mux_rr_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    for (int i = 0; i < CHANNELS; i++) bus.in_bus[i*WIDTH +: WIDTH] = word(i);
    bus.req       = '1;
    bus.out_ready = 1'b0;
    reset         = 1'b1;

    // 1: reset held two cycles with every channel requesting
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ack",   64'(bus.ack),       64'd0);
      chk("rst_sel",   64'(bus.grant_sel), 64'd0);
      chk("rst_data",  64'(bus.out_data),  64'd0);
    end
    reset   = 1'b0;
    bus.req = '0;
    tick();
    chk("idle_valid", 64'(bus.out_valid), 64'd0);

    // 2: single request on channel 3, one-cycle latency
    bus.in_bus[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    bus.req = 10'h008;
    #1;
    chk("t2_ack", 64'(bus.ack), 64'h008);
    tick();
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_data",  64'(bus.out_data),  64'hDEAD_BEEF);
    chk("t2_sel",   64'(bus.grant_sel), 64'd3);
    bus.req = '0;
    #1;
    chk("t2_ack_idle", 64'(bus.ack), 64'd0);
    bus.in_bus[3*WIDTH +: WIDTH] = word(3);

    // restart from ptr=0 for the rotation test
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // 3: all requesting, downstream always ready -> 0..9,0,1
    bus.req       = 10'h3FF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("t3_ack", 64'(bus.ack), 64'(10'(1) << (k % 10)));
      tick();
      chk("t3_sel",   64'(bus.grant_sel), 64'(k % 10));
      chk("t3_data",  64'(bus.out_data),  64'(word(k % 10)));
      chk("t3_valid", 64'(bus.out_valid), 64'd1);
    end

    // 4: stall for five cycles holding channel 1, then resume with channel 2
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_ack", 64'(bus.ack), 64'd0);
      tick();
      chk("t4_sel",   64'(bus.grant_sel), 64'd1);
      chk("t4_data",  64'(bus.out_data),  64'(word(1)));
      chk("t4_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_resume_ack", 64'(bus.ack), 64'h004);
    tick();
    chk("t4_resume_sel", 64'(bus.grant_sel), 64'd2);

    // 5: grant 8 moves ptr to 9; with req 2 and 9, 9 wins then wraps to 2
    bus.req = 10'h100;
    #1;
    chk("t5_ack8", 64'(bus.ack), 64'h100);
    tick();
    chk("t5_sel8", 64'(bus.grant_sel), 64'd8);
    bus.req = 10'h204;
    #1;
    chk("t5_ack9", 64'(bus.ack), 64'h200);
    tick();
    chk("t5_sel9",  64'(bus.grant_sel), 64'd9);
    chk("t5_data9", 64'(bus.out_data),  64'(word(9)));
    #1;
    chk("t5_ack2", 64'(bus.ack), 64'h004);
    tick();
    chk("t5_sel2",  64'(bus.grant_sel), 64'd2);
    chk("t5_data2", 64'(bus.out_data),  64'(word(2)));

    // 6: reset while FULL and stalled; the held word is dropped
    bus.out_ready = 1'b0;
    bus.req       = 10'h3FF;
    tick();
    chk("t6_full", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_ack", 64'(bus.ack), 64'd0);
    tick();
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_sel",   64'(bus.grant_sel), 64'd0);
    chk("t6_data",  64'(bus.out_data),  64'd0);
    reset   = 1'b0;
    bus.req = 10'h020;
    #1;
    chk("t6_ack5", 64'(bus.ack), 64'h020);
    tick();
    chk("t6_valid5", 64'(bus.out_valid), 64'd1);
    chk("t6_sel5",   64'(bus.grant_sel), 64'd5);
    chk("t6_data5",  64'(bus.out_data),  64'(word(5)));

    // drain, then out_ready while EMPTY must not do anything
    bus.req       = '0;
    bus.out_ready = 1'b1;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("empty_ready_valid", 64'(bus.out_valid), 64'd0);
    chk("empty_ready_ack",   64'(bus.ack),       64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
